// File: rtl/cu_pkg.sv
// Shared opcode map, FSM state encoding and opcode class helpers
// for the multi-cycle control unit.
package cu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_MOV = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_LT  = 4'hA;
   localparam logic [3:0] OP_EQ  = 4'hB;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      READ,
      EXEC,
      WRITE
   } state_t;

   function automatic logic is_alu(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_NOT, OP_SHL, OP_SHR, OP_LT, OP_EQ: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_cmp(input logic [3:0] op);
      return (op == OP_LT) || (op == OP_EQ);
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier; anything above OP_EQ is illegal,
// including any set bit above the low nibble.
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int ALU_OP_W = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic                legal,
   output logic                is_nop,
   output logic                is_mov,
   output logic                is_alu_op,
   output logic                is_cmp_op,
   output logic [ALU_OP_W-1:0] alu_op
);

   logic [3:0] op4;

   assign op4 = opcode[3:0];

   always_comb begin
      legal     = (opcode <= OPCODE_W'(OP_EQ));
      is_nop    = legal && (op4 == OP_NOP);
      is_mov    = legal && (op4 == OP_MOV);
      is_alu_op = legal && is_alu(op4);
      is_cmp_op = legal && is_cmp(op4);
      alu_op    = '0;
      if (is_alu_op) begin
         alu_op = ALU_OP_W'(op4 - 4'd1);
      end
   end

endmodule

// File: rtl/cu_fsm.sv
// Multi-cycle control unit: accepts one instruction, then sequences
// RAM read, ALU execute and RAM write-back with a bounded mem wait.
module cu_fsm
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int ADDR_W   = 8,
   parameter int ALU_OP_W = 4,
   parameter int WAIT_MAX = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [OPCODE_W+2*ADDR_W-1:0] instr,
   input  logic                         instr_valid,
   output logic                         instr_ready,
   input  logic                         mem_ready,
   output logic                         ram_read,
   output logic                         ram_write,
   output logic [ADDR_W-1:0]            ram_addr,
   output logic                         alu_enable,
   output logic [ALU_OP_W-1:0]          alu_op,
   output logic                         cmp_we,
   output logic                         done,
   output logic                         illegal,
   output logic                         timeout
);

   localparam int IW = OPCODE_W + 2 * ADDR_W;
   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     instr_q, instr_d;

   logic [OPCODE_W-1:0] opcode;
   logic [ADDR_W-1:0]   dst;
   logic [ADDR_W-1:0]   src;
   logic                dec_legal;
   logic                dec_nop;
   logic                dec_mov;
   logic                dec_alu;
   logic                dec_cmp;
   logic [ALU_OP_W-1:0] dec_alu_op;
   logic                expired;

   assign src    = instr_q[ADDR_W-1:0];
   assign dst    = instr_q[2*ADDR_W-1:ADDR_W];
   assign opcode = instr_q[IW-1:2*ADDR_W];

   cu_decode #(
      .OPCODE_W (OPCODE_W),
      .ALU_OP_W (ALU_OP_W)
   ) u_decode (
      .opcode    (opcode),
      .legal     (dec_legal),
      .is_nop    (dec_nop),
      .is_mov    (dec_mov),
      .is_alu_op (dec_alu),
      .is_cmp_op (dec_cmp),
      .alu_op    (dec_alu_op)
   );

   // Counter saturates at CNT_MAX; a miss there ends the RAM state.
   assign expired = (cnt_q == CNT_MAX) && !mem_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      instr_d = instr_q;
      unique case (state_q)
         IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (dec_mov || dec_alu) begin
               state_d = READ;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (mem_ready) begin
               state_d = dec_mov ? WRITE : EXEC;
            end else if (expired) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         EXEC: begin
            state_d = dec_cmp ? IDLE : WRITE;
         end
         WRITE: begin
            if (mem_ready || expired) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
      end
   end

   // Outputs are forced low during reset so an abort never pulses.
   always_comb begin
      instr_ready = 1'b0;
      ram_read    = 1'b0;
      ram_write   = 1'b0;
      ram_addr    = '0;
      alu_enable  = 1'b0;
      alu_op      = '0;
      cmp_we      = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      timeout     = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: instr_ready = 1'b1;
            DECODE: begin
               done    = dec_nop;
               illegal = !dec_legal;
            end
            READ: begin
               ram_read = 1'b1;
               ram_addr = src;
               timeout  = expired;
            end
            EXEC: begin
               alu_enable = 1'b1;
               alu_op     = dec_alu_op;
               cmp_we     = dec_cmp;
               done       = dec_cmp;
            end
            WRITE: begin
               ram_write = 1'b1;
               ram_addr  = dst;
               done      = mem_ready;
               timeout   = expired;
            end
            default: ;
         endcase
      end
   end

endmodule
